cpu_bus_master: RTL and testbench

CPU-side initiator for the asynchronous-style CS_/OE_/WR_ peripheral bus used by the register-file slaves. It accepts single read or write requests on a simple valid/ready interface and sequences one bus cycle per request: setup, strobe, hold. It drives Addr, the chip select and the strobes, and drives data_bus only during write cycles. Read data is returned on a one-cycle response pulse. It sits between on-chip request logic and the shared 8-bit peripheral bus.

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/cpu_bus_master.sv | 121 ++++++++++++
 tb/tb_cpu_bus_master.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CS_/OE_/WR_ peripheral bus master.
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStrobe,
      StHold
   } bus_state_e;

   localparam int unsigned DefAddrW = 8;
   localparam int unsigned DefDataW = 8;

   typedef struct packed {
      logic cs_n;
      logic oe_n;
      logic wr_n;
   } bus_ctl_t;

   localparam bus_ctl_t BusIdle = '{cs_n: 1'b1, oe_n: 1'b1, wr_n: 1'b1};

endpackage

// File: rtl/cpu_bus_master.sv
// Single-request initiator for the CS_/OE_/WR_ peripheral bus.
// Each request runs one setup, strobe and hold sequence, and every bus pin comes from a flop.
module cpu_bus_master
   import cpu_bus_pkg::*;
#(
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned ADDR_W        = DefAddrW,
   parameter int unsigned DATA_W        = DefDataW
) (
   input  logic              clk_cpu,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              CS_,
   output logic              OE_,
   output logic              WR_,
   output logic [ADDR_W-1:0] Addr,
   inout  wire  [DATA_W-1:0] data_bus
);

   localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES);

   bus_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   bus_ctl_t          ctl_q, ctl_d;
   logic              drv_en_q, drv_en_d;
   logic              rsp_valid_q, rsp_valid_d;

   assign req_ready = (state_q == StIdle) && !rst;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               state_d = StSetup;
               wr_d    = req_wr;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end
         end
         StSetup: begin
            state_d = StStrobe;
            cnt_d   = StrobeLoad;
         end
         StStrobe: begin
            if (cnt_q <= 4'd1) begin
               state_d = StHold;
               // Read data is captured on the edge that ends the last strobe cycle.
               if (!wr_q) rdata_d = data_bus;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHold: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Bus pins are registered versions of what the next state requires.
      ctl_d = BusIdle;
      if (state_d != StIdle) ctl_d.cs_n = 1'b0;
      if (state_d == StStrobe) begin
         if (wr_d) ctl_d.wr_n = 1'b0;
         else      ctl_d.oe_n = 1'b0;
      end
      drv_en_d    = wr_d && (state_d != StIdle);
      rsp_valid_d = (state_d == StHold);
   end

   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         ctl_q       <= BusIdle;
         drv_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         ctl_q       <= ctl_d;
         drv_en_q    <= drv_en_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign CS_       = ctl_q.cs_n;
   assign OE_       = ctl_q.oe_n;
   assign WR_       = ctl_q.wr_n;
   assign Addr      = addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign data_bus  = drv_en_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: table-driven transactions on two instances (STROBE_CYCLES 2 and 1)
// plus back-to-back and mid-strobe reset sequences against a register-file slave model.
module tb_cpu_bus_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       req_wr;
   logic [7:0] req_addr, req_wdata;

   logic       valid_a, ready_a, rsp_a, cs_a, oe_a, wr_a;
   logic [7:0] rdata_a, addr_a;
   wire  [7:0] data_a;
   logic       valid_b, ready_b, rsp_b, cs_b, oe_b, wr_b;
   logic [7:0] rdata_b, addr_b;
   wire  [7:0] data_b;

   cpu_bus_master #(.STROBE_CYCLES(2), .ADDR_W(8), .DATA_W(8)) dut_a (
      .clk_cpu(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_a), .rsp_rdata(rdata_a),
      .CS_(cs_a), .OE_(oe_a), .WR_(wr_a), .Addr(addr_a), .data_bus(data_a)
   );

   cpu_bus_master #(.STROBE_CYCLES(1), .ADDR_W(8), .DATA_W(8)) dut_b (
      .clk_cpu(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_b), .rsp_rdata(rdata_b),
      .CS_(cs_b), .OE_(oe_b), .WR_(wr_b), .Addr(addr_b), .data_bus(data_b)
   );

   // Slave models: drive when CS_ and OE_ are both low, store while CS_ and WR_ are low.
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   assign data_a = (!cs_a && !oe_a) ? mem_a[addr_a] : 8'hzz;
   assign data_b = (!cs_b && !oe_b) ? mem_b[addr_b] : 8'hzz;
   always @(posedge clk) begin
      if (!cs_a && !wr_a) mem_a[addr_a] <= data_a;
      if (!cs_b && !wr_b) mem_b[addr_b] <= data_b;
   end

   bit         sel;
   logic       m_ready, m_rsp, m_cs, m_oe, m_wr, m_en;
   logic [7:0] m_rdata, m_addr, m_data;
   always_comb begin
      m_ready = sel ? ready_b : ready_a;
      m_rsp   = sel ? rsp_b   : rsp_a;
      m_cs    = sel ? cs_b    : cs_a;
      m_oe    = sel ? oe_b    : oe_a;
      m_wr    = sel ? wr_b    : wr_a;
      m_rdata = sel ? rdata_b : rdata_a;
      m_addr  = sel ? addr_b  : addr_a;
      m_data  = sel ? data_b  : data_a;
      m_en    = sel ? dut_b.drv_en_q : dut_a.drv_en_q;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit         sel;
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   task automatic run_txn(input vec_t v);
      int sc, cs_lo, wr_lo, oe_lo, rsp_n, rsp_at, rdy_lo, bad_data, bad_addr, en_n;
      logic [7:0] rd;
      sc = v.sel ? 1 : 2;
      cs_lo = 0; wr_lo = 0; oe_lo = 0; rsp_n = 0; rsp_at = 0; rdy_lo = 0;
      bad_data = 0; bad_addr = 0; en_n = 0; rd = 8'h00;
      sel = v.sel;
      @(negedge clk);
      req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
      if (v.sel) valid_b = 1'b1;
      else       valid_a = 1'b1;
      #1 check("ready_at_accept", m_ready, 1);
      for (int k = 1; k <= sc + 3; k++) begin
         @(negedge clk);
         if (k == 1) begin valid_a = 1'b0; valid_b = 1'b0; end
         if (!m_cs) begin
            cs_lo++;
            if (m_addr !== v.addr) bad_addr++;
            if (v.wr && (m_en !== 1'b1 || m_data !== v.wdata)) bad_data++;
         end
         if (!m_wr) wr_lo++;
         if (!m_oe) oe_lo++;
         if (!m_ready) rdy_lo++;
         if (!v.wr && m_en) en_n++;
         if (m_rsp) begin rsp_n++; rsp_at = k; rd = m_rdata; end
      end
      check("cs_low_cycles", cs_lo, sc + 2);
      check("ready_low_cycles", rdy_lo, sc + 2);
      check("rsp_count", rsp_n, 1);
      check("rsp_latency", rsp_at, sc + 2);
      check("addr_stable", bad_addr, 0);
      if (v.wr) begin
         check("wr_low_cycles", wr_lo, sc);
         check("oe_low_on_write", oe_lo, 0);
         check("write_data_driven", bad_data, 0);
         check("slave_stored", v.sel ? mem_b[v.addr] : mem_a[v.addr], v.wdata);
      end else begin
         check("oe_low_cycles", oe_lo, sc);
         check("wr_low_on_read", wr_lo, 0);
         check("drive_en_on_read", en_n, 0);
         check("read_data", rd, v.exp_rdata);
      end
   endtask

   vec_t vecs [7];
   int   n;
   int   rsp_seen;

   initial begin
      for (int i = 0; i < 256; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end
      mem_a[2] = 8'hA5;

      vecs[0] = '{sel: 0, wr: 1, addr: 8'h01, wdata: 8'h5A, exp_rdata: 8'h00};
      vecs[1] = '{sel: 0, wr: 0, addr: 8'h01, wdata: 8'h00, exp_rdata: 8'h5A};
      vecs[2] = '{sel: 0, wr: 0, addr: 8'h02, wdata: 8'h00, exp_rdata: 8'hA5};
      vecs[3] = '{sel: 0, wr: 1, addr: 8'h80, wdata: 8'h3C, exp_rdata: 8'h00};
      vecs[4] = '{sel: 0, wr: 0, addr: 8'h80, wdata: 8'h00, exp_rdata: 8'h3C};
      vecs[5] = '{sel: 1, wr: 1, addr: 8'h01, wdata: 8'hC3, exp_rdata: 8'h00};
      vecs[6] = '{sel: 1, wr: 0, addr: 8'h01, wdata: 8'h00, exp_rdata: 8'hC3};

      rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; sel = 1'b0;
      req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", m_ready, 0);
      check("reset_cs", m_cs, 1);
      check("reset_oe", m_oe, 1);
      check("reset_wr", m_wr, 1);
      check("reset_addr", m_addr, 0);
      check("reset_drive_en", m_en, 0);
      check("reset_rsp_valid", m_rsp, 0);
      check("reset_rsp_rdata", m_rdata, 0);
      rst = 1'b0;
      #1 check("ready_after_reset", m_ready, 1);

      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      // Back-to-back: valid held high, write 0x03 <- 0x11 then read 0x03.
      sel = 1'b0;
      @(negedge clk);
      req_wr = 1'b1; req_addr = 8'h03; req_wdata = 8'h11; valid_a = 1'b1;
      @(negedge clk);
      req_wr = 1'b0;
      n = 0;
      while (!m_ready && n < 20) begin n++; @(negedge clk); end
      check("b2b_ready_low", n, 4);
      check("b2b_turnaround_cs", m_cs, 1);
      @(negedge clk);
      valid_a = 1'b0;
      n = 0;
      while (!m_rsp && n < 20) begin n++; @(negedge clk); end
      check("b2b_rsp_seen", m_rsp, 1);
      check("b2b_read_data", m_rdata, 8'h11);

      // Reset asserted during the second strobe cycle of a write.
      @(negedge clk);
      req_wr = 1'b1; req_addr = 8'h04; req_wdata = 8'h77; valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_strobe_wr_low", m_wr, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_cs_high", m_cs, 1);
      check("rst_wr_high", m_wr, 1);
      check("rst_oe_high", m_oe, 1);
      check("rst_bus_released", m_en, 0);
      check("rst_no_rsp", m_rsp, 0);
      check("rst_ready_low", m_ready, 0);
      rst = 1'b0;
      #1 check("rst_ready_after", m_ready, 1);
      rsp_seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (m_rsp) rsp_seen++;
      end
      check("rst_dropped_no_rsp", rsp_seen, 0);
      check("rst_idle_ready", m_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
